// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem request handshake, instruction register
module fetch_unit #(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ins_valid,
    input  logic               ins_ack,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         opcode,
    output logic [3:0]         func,
    output logic [ADDR_W-1:0]  ins_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [ADDR_W-1:0]   ins_pc_q, ins_pc_d;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_START;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            ir_q       <= '0;
            ins_pc_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ir_q       <= ir_d;
            ins_pc_q   <= ins_pc_d;
        end
    end

    // Redirect outranks both the memory response and the downstream ack.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        ir_d       = ir_q;
        ins_pc_d   = ins_pc_q;
        case (state_q)
            S_START: begin
                state_d = S_FETCH;
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (imem_ready) begin
                    ir_d       = imem_rdata;
                    ins_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_ONE;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = S_FETCH;
                end else if (ins_ack) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    always_comb begin
        imem_req  = (state_q == S_FETCH);
        ins_valid = (state_q == S_HOLD);
    end

    assign imem_addr = fetch_pc_q;
    assign instr     = ir_q;
    assign opcode    = ir_q[15:13];
    assign func      = ir_q[3:0];
    assign ins_pc    = ins_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed plus randomized check of fetch_unit against a behavioural model
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        ins_valid;
    logic        ins_ack;
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic [3:0]  func;
    logic [15:0] ins_pc;
    logic        redirect;
    logic [15:0] redirect_pc;

    int errors = 0;
    int checks = 0;

    // Model: whether the stage has left reset, whether it holds an instruction.
    bit          m_started;
    bit          m_holding;
    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_ins_pc;

    fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .ins_valid   (ins_valid),
        .ins_ack     (ins_ack),
        .instr       (instr),
        .opcode      (opcode),
        .func        (func),
        .ins_pc      (ins_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_started = 0; m_holding = 0; m_pc = 16'h0000; m_ir = 16'h0000; m_ins_pc = 16'h0000;
        end else if (!m_started) begin
            m_started = 1;
            if (redirect) m_pc = redirect_pc;
        end else if (!m_holding) begin
            if (redirect) begin
                m_pc = redirect_pc;
            end else if (imem_ready) begin
                m_ir = imem_rdata; m_ins_pc = m_pc; m_pc = m_pc + 16'd1; m_holding = 1;
            end
        end else begin
            if (redirect) begin
                m_pc = redirect_pc; m_holding = 0;
            end else if (ins_ack) begin
                m_holding = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("imem_req",  {15'd0, imem_req},  {15'd0, m_started && !m_holding});
        check("ins_valid", {15'd0, ins_valid}, {15'd0, m_holding});
        check("imem_addr", imem_addr, m_pc);
        check("instr",     instr, m_ir);
        check("opcode",    {13'd0, opcode}, {13'd0, m_ir[15:13]});
        check("func",      {12'd0, func},   {12'd0, m_ir[3:0]});
        check("ins_pc",    ins_pc, m_ins_pc);
    endtask

    task automatic step(input bit r, input bit rd, input logic [15:0] rpc,
                        input bit rdy, input logic [15:0] data, input bit ack);
        reset = r; redirect = rd; redirect_pc = rpc;
        imem_ready = rdy; imem_rdata = data; ins_ack = ack;
        @(posedge CLK);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1; redirect = 0; redirect_pc = 0; imem_ready = 0; imem_rdata = 0; ins_ack = 0;

        // Reset and first fetch
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_req", {15'd0, imem_req}, 16'd0);
        check("rst_valid", {15'd0, ins_valid}, 16'd0);
        check("rst_instr", instr, 16'h0000);
        step(0, 0, 0, 0, 0, 0);
        check("first_req", {15'd0, imem_req}, 16'd1);
        check("first_addr", imem_addr, 16'h0000);

        // Zero-wait stream
        step(0, 0, 0, 1, 16'h0001, 0);
        check("s0_valid", {15'd0, ins_valid}, 16'd1);
        check("s0_func", {12'd0, func}, 16'd1);
        check("s0_pc", ins_pc, 16'd0);
        step(0, 0, 0, 1, 16'h0000, 1);
        step(0, 0, 0, 1, 16'h2002, 0);
        check("s1_op", {13'd0, opcode}, 16'd1);
        check("s1_func", {12'd0, func}, 16'd2);
        check("s1_pc", ins_pc, 16'd1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 16'h4003, 0);
        check("s2_op", {13'd0, opcode}, 16'd2);
        check("s2_pc", ins_pc, 16'd2);
        step(0, 0, 0, 0, 0, 1);
        check("s3_addr", imem_addr, 16'd3);

        // Stalls on memory then downstream
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 16'hBEEF, 0);
        check("stall_addr", imem_addr, 16'd3);
        step(0, 0, 0, 1, 16'hE000, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
        check("hold_op", {13'd0, opcode}, 16'd7);
        check("hold_valid", {15'd0, ins_valid}, 16'd1);
        check("hold_pc", ins_pc, 16'd3);
        step(0, 0, 0, 0, 0, 1);
        check("adv_once", imem_addr, 16'd4);

        // Redirect in HOLD with simultaneous ack
        step(0, 0, 0, 1, 16'h1234, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 16'h0005, 0);
        check("pre_redir_pc", ins_pc, 16'd5);
        step(0, 1, 16'h0040, 0, 0, 1);
        check("redir_valid", {15'd0, ins_valid}, 16'd0);
        check("redir_addr", imem_addr, 16'h0040);
        step(0, 0, 0, 1, 16'h0005, 0);
        check("redir_inspc", ins_pc, 16'h0040);
        step(0, 0, 0, 0, 0, 1);

        // Redirect during FETCH discards returned word
        step(0, 1, 16'h0010, 1, 16'hFFFF, 0);
        check("fr_addr", imem_addr, 16'h0010);
        check("fr_req", {15'd0, imem_req}, 16'd1);
        check("fr_instr", instr, 16'h0005);

        // Wrap and mid-op reset
        step(0, 1, 16'hFFFF, 0, 0, 0);
        step(0, 0, 0, 1, 16'h6001, 0);
        check("wrap_inspc", ins_pc, 16'hFFFF);
        check("wrap_addr", imem_addr, 16'h0000);
        step(1, 0, 0, 0, 0, 0);
        check("mr_valid", {15'd0, ins_valid}, 16'd0);
        check("mr_req", {15'd0, imem_req}, 16'd0);
        check("mr_instr", instr, 16'h0000);
        step(0, 0, 0, 0, 0, 0);
        check("mr_restart", imem_addr, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) < 2), ($urandom_range(99) < 10), 16'($urandom),
                 $urandom_range(1), 16'($urandom), $urandom_range(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the Control unit.
- Holds the program counter and requests 16-bit instruction words from instruction memory over a ready handshake.
- Latches each fetched word into an instruction register and presents its opcode/func fields to Control with a valid/ack handshake.
- Accepts PC redirects from the branch/jump path, which is driven by Control's Branch/JumpOut result, and squashes the held instruction when a redirect arrives.

Parameters:
ADDR_W, 16, width of instruction address / PC (word-addressed)
INSTR_W, 16, instruction word width (fixed field map below; must be 16)
RESET_PC, 0, first fetch address after reset

Ports:
CLK  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  fetch address (equals fetch_pc)
imem_ready  input  1  memory returns imem_rdata this cycle; meaningful only while imem_req=1
imem_rdata  input  INSTR_W  instruction word
ins_valid  output  1  instruction register holds a live instruction
ins_ack  input  1  downstream consumes the instruction this cycle
instr  output  INSTR_W  instruction register contents
opcode  output  3  instr[15:13], to Control.opcode
func  output  4  instr[3:0], to Control.func
ins_pc  output  ADDR_W  address the held instruction was fetched from
redirect  input  1  load redirect_pc; squash in-flight/held instruction
redirect_pc  input  ADDR_W  new fetch address

Behaviour:
- Registers: state, fetch_pc, ir, ins_pc.
- FSM states: S_START, S_FETCH, S_HOLD.
- Outputs decode from state:
  - imem_req=1 only in S_FETCH.
  - ins_valid=1 only in S_HOLD.
  - imem_addr=fetch_pc at all times.
- instr/opcode/func come combinationally from ir and hold their last value outside S_HOLD.
- Reset (reset=1 at an edge, in any state, mid-handshake included): state=S_START, fetch_pc=RESET_PC, ir=0, ins_pc=0.
  - Resulting outputs: imem_req=0, ins_valid=0, instr=0, opcode=0, func=0, ins_pc=0.
  - Reset takes priority over every other input.
- S_START: go to S_FETCH. If redirect=1, fetch_pc<=redirect_pc; otherwise fetch_pc is unchanged.
- S_FETCH, in priority order:
  - redirect=1: fetch_pc<=redirect_pc, stay in S_FETCH, discard imem_rdata even if imem_ready=1.
  - else imem_ready=1: ir<=imem_rdata, ins_pc<=fetch_pc, fetch_pc<=fetch_pc+1, go to S_HOLD.
  - else stay in S_FETCH with request and address held stable.
- S_HOLD, in priority order:
  - redirect=1: fetch_pc<=redirect_pc, go to S_FETCH. The held instruction is dropped and ir is not cleared. An ins_ack in the same cycle is ignored, so redirect wins.
  - else ins_ack=1: go to S_FETCH.
  - else stay in S_HOLD; ir, ins_pc and fetch_pc stay stable.
- Latency:
  - imem_ready in the same cycle as the first imem_req gives ins_valid=1 on the next cycle.
  - The first request appears 1 cycle after reset deasserts.
  - Best-case throughput is one instruction per 2 cycles.
- Arithmetic: fetch_pc+1 is computed modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000 without error.
- Memory assumptions: imem must tolerate an abandoned request (address change while imem_req=1 on redirect). imem_ready while imem_req=0 is ignored.
- Downstream contract: Control registers opcode/func on the edge where ins_valid & ins_ack. Holding ir stable in S_HOLD guarantees a clean sample.

Test Plan:
- Reset/first fetch: assert reset 2 cycles, release -> cycle 0 imem_req=0, ins_valid=0, opcode=0, func=0; cycle 1 imem_req=1, imem_addr=0.
- Zero-wait stream: imem_ready=1 always, ins_ack=1 when valid, rdata 0x0001,0x2002,0x4003 -> ins_valid every other cycle; (opcode,func)=(0,1),(1,2),(2,3); ins_pc=0,1,2.
- Stalls: imem_ready low 3 cycles then high with 0xE000, then ins_ack low 4 cycles -> imem_addr stable during wait; ins_valid held 5 cycles with opcode=7, func=0, ins_pc stable; fetch_pc advances exactly once.
- Redirect in HOLD with simultaneous ack: holding ins_pc=5, redirect=1 and ins_ack=1, redirect_pc=0x0040 -> ins_valid drops next cycle, imem_addr=0x0040; next instruction reports ins_pc=0x0040.
- Redirect during FETCH with imem_ready=1: rdata 0xFFFF discarded, redirect_pc=0x0010 -> stays in FETCH at 0x0010; the 0xFFFF word never appears on instr.
- Wrap and mid-op reset: redirect to 0xFFFF, fetch -> ins_pc=0xFFFF, next imem_addr=0x0000; assert reset while ins_valid=1 -> next cycle ins_valid=0, imem_req=0, then fetch restarts at RESET_PC.
